// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int GROUP_W = 4;

    // Lookahead summary of one 4-bit group
    typedef struct packed {
        logic g;
        logic p;
        logic c_out;
    } cla_gp_t;

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: sum bits, group generate/propagate,
// carry out of the group and carry into its top bit.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] i_a,
    input  logic [GROUP_W-1:0] i_b,
    input  logic               i_cin,
    output logic [GROUP_W-1:0] o_sum,
    output cla_gp_t            o_gp,
    output logic               o_c3
);

    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Fully flattened lookahead so every carry is two logic levels from the inputs
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_gp.g     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                      | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_gp.p     = &w_p;
    assign o_gp.c_out = o_gp.g | (o_gp.p & i_cin);

    assign o_sum = w_p ^ w_c;
    assign o_c3  = w_c[3];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder, one 4-bit group per stage, valid/ready handshake.
// Define PIPELINED_CLA_OVF_EN to build the registered signed-overflow output.
module pipelined_cla_adder #(
    parameter int WIDTH   = 16,
    parameter int GROUP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    import cla_pkg::*;

    localparam int STAGES = WIDTH / GROUP_W;

    if (GROUP_W != cla_pkg::GROUP_W) begin : g_badGroupW
        $error("pipelined_cla_adder: GROUP_W must be 4");
    end
    if (WIDTH < 4 || WIDTH > 64 || (WIDTH % 4) != 0) begin : g_badWidth
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
    end

    logic              w_en;
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_carry;

    // The whole pipeline moves as one unit; a stalled output freezes every stage
    assign w_en      = !r_valid[STAGES-1] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_valid[STAGES-1];
    assign cout      = w_carry[STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_en) begin
            r_valid[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GROUP_W-1:0] w_a;
        logic [GROUP_W-1:0] w_b;
        logic [GROUP_W-1:0] w_sum;
        logic               w_cin;
        logic               w_c3;
        cla_gp_t            w_gp;
        logic               r_carry;
        logic [GROUP_W-1:0] r_sumDly [STAGES-k];

        if (k == 0) begin : g_direct
            assign w_a   = a[GROUP_W-1:0];
            assign w_b   = b[GROUP_W-1:0];
            assign w_cin = cin;
        end else begin : g_delayed
            // Operands of group k wait k cycles so they meet the carry from group k-1
            logic [GROUP_W-1:0] r_aDly [k];
            logic [GROUP_W-1:0] r_bDly [k];

            always_ff @(posedge clk) begin
                if (w_en) begin
                    r_aDly[0] <= a[GROUP_W*k +: GROUP_W];
                    r_bDly[0] <= b[GROUP_W*k +: GROUP_W];
                    for (int i = 1; i < k; i++) begin
                        r_aDly[i] <= r_aDly[i-1];
                        r_bDly[i] <= r_bDly[i-1];
                    end
                end
            end

            assign w_a   = r_aDly[k-1];
            assign w_b   = r_bDly[k-1];
            assign w_cin = w_carry[k-1];
        end

        cla_group4 u_group (
            .i_a   (w_a),
            .i_b   (w_b),
            .i_cin (w_cin),
            .o_sum (w_sum),
            .o_gp  (w_gp),
            .o_c3  (w_c3)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_carry <= 1'b0;
                for (int i = 0; i < STAGES-k; i++) begin
                    r_sumDly[i] <= '0;
                end
            end else if (w_en) begin
                r_carry     <= w_gp.c_out;
                r_sumDly[0] <= w_sum;
                for (int i = 1; i < STAGES-k; i++) begin
                    r_sumDly[i] <= r_sumDly[i-1];
                end
            end
        end

        assign sum[GROUP_W*k +: GROUP_W] = r_sumDly[STAGES-1-k];
        assign w_carry[k]                = r_carry;
    end

`ifdef PIPELINED_CLA_OVF_EN
    logic r_ovf;

    // Carry into the MSB differs from carry out exactly when the signed result overflows
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= g_stage[STAGES-1].w_c3 ^ g_stage[STAGES-1].w_gp.c_out;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed and random transactions
// scored against an arithmetic reference queue.
module tb_pipelined_cla_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = WIDTH / 4;
    localparam int BOUND  = 4 * STAGES + 8;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        logic [31:0]      cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks      = 0;
    int errors      = 0;
    int tickCount   = 0;
    int popCount    = 0;
    int firstPopCyc = -1;
    int lastPopCyc  = -1;
    int lastLatency = -1;

    exp_t             q[$];
    logic             held = 1'b0;
    logic [WIDTH-1:0] heldSum;
    logic             heldCout;
    logic             heldOvf;
    logic [WIDTH-1:0] lastSum;
    logic             lastCout;
    logic             lastOvf;

    pipelined_cla_adder #(
        .WIDTH   (WIDTH),
        .GROUP_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference result from plain integer addition; overflow from the sign rule
    function automatic exp_t refModel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic c);
        logic [WIDTH:0] full;
        exp_t           e;
        full  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        e.s   = full[WIDTH-1:0];
        e.c   = full[WIDTH];
`ifdef PIPELINED_CLA_OVF_EN
        e.o   = (x[WIDTH-1] == y[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
`else
        e.o   = 1'b0;
`endif
        e.cyc = '0;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then score the cycle at the falling edge
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input logic c, input logic ordy);
        exp_t e;
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = c;
        out_ready = ordy;
        @(negedge clk);
        if (rst_n) begin
            if (held) begin
                checkOutput("stallValid", 64'(out_valid), 64'd1);
                checkOutput("stallSum",   64'(sum),       64'(heldSum));
                checkOutput("stallCout",  64'(cout),      64'(heldCout));
                checkOutput("stallOvf",   64'(ovf),       64'(heldOvf));
            end
            held     = out_valid && !out_ready;
            heldSum  = sum;
            heldCout = cout;
            heldOvf  = ovf;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checkOutput("spuriousOut", 64'(out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    checkOutput("sum",  64'(sum),  64'(e.s));
                    checkOutput("cout", 64'(cout), 64'(e.c));
                    checkOutput("ovf",  64'(ovf),  64'(e.o));
                    lastLatency = tickCount - int'(e.cyc);
                    lastSum     = sum;
                    lastCout    = cout;
                    lastOvf     = ovf;
                    popCount++;
                    if (firstPopCyc < 0) firstPopCyc = tickCount;
                    lastPopCyc = tickCount;
                end
            end
            if (in_valid && in_ready) begin
                e     = refModel(x, y, c);
                e.cyc = 32'(tickCount);
                q.push_back(e);
            end
        end else begin
            held = 1'b0;
        end
        tickCount++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < BOUND && q.size() != 0; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        end
        checkOutput(tag, 64'(q.size()), 64'd0);
    endtask

    task automatic runSingle(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input logic c);
        int base = popCount;
        applyStimulus(1'b1, x, y, c, 1'b1);
        for (int i = 0; i < BOUND && popCount == base; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        end
        checkOutput("singleDelivered", 64'(popCount - base), 64'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        int               base;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("rstOutValid", 64'(out_valid), 64'd0);
        checkOutput("rstSum",      64'(sum),       64'd0);
        checkOutput("rstCout",     64'(cout),      64'd0);
        checkOutput("rstOvf",      64'(ovf),       64'd0);
        checkOutput("rstInReady",  64'(in_ready),  64'd1);
        rst_n = 1'b1;

        // Single transaction: latency and a single result pulse
        $display("[TB] directed 0x1234 + 0x0FCD + 1");
        base = popCount;
        va   = 16'h1234;
        vb   = 16'h0FCD;
        runSingle(va, vb, 1'b1);
        checkOutput("dirSum",     64'(lastSum),     64'h2202);
        checkOutput("dirCout",    64'(lastCout),    64'd0);
        checkOutput("dirLatency", 64'(lastLatency), 64'(STAGES));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("dirOnePulse",  64'(popCount - base), 64'd1);
        checkOutput("dirIdleValid", 64'(out_valid),       64'd0);

        $display("[TB] wrap-around and overflow vectors");
        va = '1;
        vb = '0;
        runSingle(va, vb, 1'b1);
        checkOutput("wrapSum",  64'(lastSum),  64'd0);
        checkOutput("wrapCout", 64'(lastCout), 64'd1);
        va = {1'b0, {(WIDTH-1){1'b1}}};
        vb = {{(WIDTH-1){1'b0}}, 1'b1};
        runSingle(va, vb, 1'b0);
        checkOutput("ovfSum",  64'(lastSum),  64'(1) << (WIDTH-1));
        checkOutput("ovfCout", 64'(lastCout), 64'd0);
`ifdef PIPELINED_CLA_OVF_EN
        checkOutput("ovfFlag", 64'(lastOvf), 64'd1);
`else
        checkOutput("ovfFlag", 64'(lastOvf), 64'd0);
`endif

        $display("[TB] back-to-back eight transactions");
        popCount    = 0;
        firstPopCyc = -1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
        end
        drain("b2bDrain");
        checkOutput("b2bCount",  64'(popCount),                 64'd8);
        checkOutput("b2bSpread", 64'(lastPopCyc - firstPopCyc), 64'd7);

        $display("[TB] stall with full pipeline");
        base = popCount;
        for (int i = 0; i < STAGES; i++) begin
            applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
            checkOutput("stallInReady",  64'(in_ready),  64'd0);
            checkOutput("stallOutValid", 64'(out_valid), 64'd1);
        end
        drain("stallDrain");
        checkOutput("stallDelivered", 64'(popCount - base), 64'(STAGES));

        $display("[TB] reset with three transactions in flight");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
        end
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("midRstOutValid", 64'(out_valid), 64'd0);
        checkOutput("midRstInReady",  64'(in_ready),  64'd1);
        checkOutput("midRstSum",      64'(sum),       64'd0);
        checkOutput("midRstCout",     64'(cout),      64'd0);
        q.delete();
        rst_n = 1'b1;
        base  = popCount;
        for (int i = 0; i < 2 * STAGES + 2; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("midRstNoStale", 64'(popCount - base), 64'd0);

        $display("[TB] random traffic with bubbles and stalls");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) != 0));
        end
        drain("randDrain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4, range 4..64.
REQ-002 Parameter GROUP_W, default 4, lookahead group width; SHALL be fixed at 4 (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 in_valid  input  1  operands and cin valid this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry into bit 0.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed overflow flag; see Configuration.

Function
REQ-015 STAGES = WIDTH/4 pipeline stages; stage k computes group k (bits 4k+3..4k) with 4-bit lookahead (generate/propagate, group carry), using the carry registered from stage k-1 (stage 0 uses cin).
REQ-016 Operand bits of group k SHALL be delayed k registers, and sum bits of group k delayed STAGES-1-k registers, so that all sum bits of one transaction leave together.
REQ-017 Latency: a transaction accepted at edge N SHALL present out_valid=1 with its result after edge N+STAGES when no stall occurs (WIDTH=16: 4 cycles).
REQ-018 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-019 Pipeline advance enable en = !out_valid || out_ready; in_ready = en; all stage registers, including valid bits, update only when en=1.
REQ-020 Throughput: one transaction per cycle when out_ready held 1.
REQ-021 Bubbles: in_valid=0 while en=1 SHALL insert an invalid slot; invalid slots never assert out_valid.
REQ-022 Stall: out_valid=1, out_ready=0 SHALL freeze sum, cout, ovf, out_valid and all internal stages; no transaction lost or duplicated.
REQ-023 sum, cout, ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Ordering: results SHALL emerge in acceptance order.
REQ-025 Wrap-around: a=all-ones, b=0, cin=1 SHALL yield sum=0, cout=1.

Reset
REQ-026 While rst_n=0 at a rising edge, all stage valid bits SHALL clear; out_valid=0, sum=0, cout=0, ovf=0 after that edge.
REQ-027 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-028 Reset mid-operation SHALL discard all in-flight transactions; no partial result appears afterwards.
REQ-029 Data-path registers other than those driving outputs need no reset.

Configuration
REQ-030 Macro PIPELINED_CLA_OVF_EN: when defined, ovf = carry into MSB XOR cout for the output transaction, registered and aligned with sum.
REQ-031 When PIPELINED_CLA_OVF_EN is undefined, ovf SHALL be constant 0 and no overflow logic or registers are built; port remains.

Structure
REQ-032 Shared package cla_pkg SHALL hold GROUP_W=4 and the group generate/propagate record type (g, p, c_out).
REQ-033 Sub-module cla_group4: combinational 4-bit group (a, b, cin -> sum, group G, group P, cout, carry into bit 3); instantiated STAGES times by generate loop.
REQ-034 Handshake/enable logic SHALL reside in pipelined_cla_adder only.

Verification
REQ-035 WIDTH=16, out_ready=1: a=0x1234, b=0x0FCD, cin=1 -> after 4 cycles sum=0x2202, cout=0, one out_valid pulse.
REQ-036 WIDTH=16: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; with OVF_EN a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0.
REQ-037 Back-to-back 8 random transactions, out_ready=1 -> 8 results on 8 consecutive cycles, matching reference model in order.
REQ-038 out_ready=0 for 5 cycles with pipeline full -> in_ready=0, outputs frozen; on release every transaction delivered exactly once in order.
REQ-039 rst_n=0 for one edge with 3 transactions in flight -> out_valid=0 next cycle, no stale result ever emitted, in_ready=1.
REQ-040 WIDTH=4 and WIDTH=64 builds: exhaustive (4-bit) / 10k random (64-bit) vectors including cin toggling -> zero mismatches, latency 1 and 16 respectively.
